oam_dma_arbiter: RTL



---
 rtl/gb_mem_pkg.sv | 24 ++
 rtl/oam_dma_sequencer.sv | 85 ++++++++
 rtl/oam_dma_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants, DMA state type and the echo-RAM source mapping
// used by the OAM DMA arbiter and its sequencer.
package gb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] IO_BASE      = 16'hFF00;
   localparam logic [15:0] HRAM_END     = 16'hFFFE;
   localparam logic [7:0]  ECHO_BASE    = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET  = 8'h20;
   localparam logic [7:0]  SRC_HI_RST   = 8'hFF;

   // Pages E0..FF alias work RAM C0..DF
   function automatic logic [7:0] map_src(input logic [7:0] hi);
      return (hi >= ECHO_BASE) ? (hi - ECHO_OFFSET) : hi;
   endfunction

endpackage

// File: rtl/oam_dma_sequencer.sv
// OAM DMA FSM: CYC_PER_BYTE-clock setup, then one byte per slot (read on phase 0,
// OAM write on phase 1); a start pulse restarts from byte 0. Never stalls.
module oam_dma_sequencer
   import gb_mem_pkg::*;
#(
   parameter int  OAM_BYTES    = 160,
   parameter int  CYC_PER_BYTE = 4,
   localparam int PH_W         = $clog2(CYC_PER_BYTE)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [7:0]      i_src_hi,
   input  logic [7:0]      i_mem_rdata,
   output logic            o_xfer,
   output logic [PH_W-1:0] o_phase,
   output logic            o_dma_active,
   output logic            o_dma_rd,
   output logic [15:0]     o_dma_addr,
   output logic            o_oam_we,
   output logic [7:0]      o_oam_addr,
   output logic [7:0]      o_oam_wdata
);

   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CYC_PER_BYTE - 1);
   localparam logic [7:0]      BYTE_LAST = 8'(OAM_BYTES - 1);

   dma_state_t      r_state;
   logic [7:0]      r_byte;
   logic [PH_W-1:0] r_phase;
   logic            r_dma_active;
   logic            w_we;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_byte       <= '0;
         r_phase      <= '0;
         r_dma_active <= 1'b0;
      end else if (i_start) begin
         r_state      <= SETUP;
         r_byte       <= '0;
         r_phase      <= '0;
         r_dma_active <= 1'b1;
      end else begin
         unique case (r_state)
            SETUP: begin
               if (r_phase == PH_LAST) begin
                  r_state <= XFER;
                  r_phase <= '0;
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            XFER: begin
               if (r_phase == PH_LAST) begin
                  r_phase <= '0;
                  if (r_byte == BYTE_LAST) begin
                     r_state      <= IDLE;
                     r_byte       <= '0;
                     r_dma_active <= 1'b0;
                  end else begin
                     r_byte <= r_byte + 8'd1;
                  end
               end else begin
                  r_phase <= r_phase + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes are gated by reset so an abort takes effect in the reset clock itself
   assign o_xfer       = (r_state == XFER);
   assign o_phase      = r_phase;
   assign o_dma_active = r_dma_active;
   assign o_dma_rd     = o_xfer && (r_phase == '0) && i_rst_n;
   assign o_dma_addr   = {map_src(i_src_hi), r_byte};
   assign w_we         = o_xfer && (r_phase == PH_W'(1)) && i_rst_n;
   assign o_oam_we     = w_we;
   assign o_oam_addr   = r_byte;
   assign o_oam_wdata  = w_we ? i_mem_rdata : 8'h00;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Owns the FF46 register and muxes the memory bus between CPU and OAM DMA;
// CPU strobes mirror combinationally when idle and are filtered during XFER.
module oam_dma_arbiter
   import gb_mem_pkg::*;
#(
   parameter int OAM_BYTES    = 160,
   parameter int CYC_PER_BYTE = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_cpu_addr,
   input  logic        i_cpu_rd,
   input  logic        i_cpu_wr,
   input  logic [7:0]  i_cpu_wdata,
   output logic [7:0]  o_cpu_rdata,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic [7:0]  o_mem_wdata,
   input  logic [7:0]  i_mem_rdata,
   output logic [7:0]  o_oam_addr,
   output logic        o_oam_we,
   output logic [7:0]  o_oam_wdata,
   output logic        o_dma_active
);

   localparam int PH_W = $clog2(CYC_PER_BYTE);

   logic [7:0]      r_src_hi;
   logic            r_rd_reg;
   logic            r_rd_blk;
   logic            w_reg_hit;
   logic            w_io_hit;
   logic            w_start;
   logic            w_xfer;
   logic            w_dma_owns;
   logic            w_cpu_pass;
   logic [PH_W-1:0] w_phase;
   logic            w_dma_rd;
   logic [15:0]     w_dma_addr;

   assign w_reg_hit = (i_cpu_addr == DMA_REG_ADDR);
   assign w_io_hit  = (i_cpu_addr >= IO_BASE) && (i_cpu_addr <= HRAM_END) && !w_reg_hit;
   assign w_start   = i_cpu_wr && w_reg_hit;
   // IO/HRAM sits on its own decoder port, so it may share the bus after the DMA slot's read/write phases
   assign w_cpu_pass = !w_xfer || (w_io_hit && (int'(w_phase) >= 2));
   assign w_dma_owns = w_xfer && i_rst_n && !w_cpu_pass;

   oam_dma_sequencer #(
      .OAM_BYTES    (OAM_BYTES),
      .CYC_PER_BYTE (CYC_PER_BYTE)
   ) u_seq (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (w_start),
      .i_src_hi     (r_src_hi),
      .i_mem_rdata  (i_mem_rdata),
      .o_xfer       (w_xfer),
      .o_phase      (w_phase),
      .o_dma_active (o_dma_active),
      .o_dma_rd     (w_dma_rd),
      .o_dma_addr   (w_dma_addr),
      .o_oam_we     (o_oam_we),
      .o_oam_addr   (o_oam_addr),
      .o_oam_wdata  (o_oam_wdata)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_src_hi <= SRC_HI_RST;
         r_rd_reg <= 1'b0;
         r_rd_blk <= 1'b0;
      end else begin
         if (w_start) r_src_hi <= i_cpu_wdata;
         r_rd_reg <= i_cpu_rd && w_reg_hit;
         r_rd_blk <= i_cpu_rd && w_xfer && !w_reg_hit && !w_cpu_pass;
      end
   end

   always_comb begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_rd    = i_cpu_rd && !w_reg_hit && i_rst_n;
      o_mem_wr    = i_cpu_wr && !w_reg_hit && i_rst_n;
      if (w_dma_owns) begin
         o_mem_addr = w_dma_addr;
         o_mem_rd   = w_dma_rd;
         o_mem_wr   = 1'b0;
      end
   end

   always_comb begin
      o_cpu_rdata = i_mem_rdata;
      if (i_rst_n && r_rd_reg)      o_cpu_rdata = r_src_hi;
      else if (i_rst_n && r_rd_blk) o_cpu_rdata = 8'hFF;
   end

endmodule
